// File: rtl/fl_alloc_ctrl.sv
// fl_alloc_ctrl: in-order dispatch grant against the freelist tag supply,
// tag steering to granted dest slots, and mispredict rollback sequencing
// (RB pulse followed by RB_WAIT_CYC recovery cycles).
// Optional build macro FL_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of tag-starvation stall cycles.

// Per-slot grant cell. Slots are chained oldest to youngest. en_i is the
// "all older slots granted" token, and used_i is the number of tags already
// consumed by older slots.
module fl_alloc_slot #(
  parameter int DP_NUM   = 2,
  parameter int PREG_IDX = 6,
  parameter int CNT_W    = 2
) (
  input  logic                               en_i,
  input  logic                               req_i,
  input  logic                               dest_i,
  input  logic [CNT_W-1:0]                   used_i,
  input  logic [CNT_W-1:0]                   avail_i,
  input  logic [DP_NUM-1:0][PREG_IDX-1:0]    tags_i,
  output logic                               grant_o,
  output logic [CNT_W-1:0]                   used_o,
  output logic [PREG_IDX-1:0]                tag_o,
  output logic                               stall_o
);
  logic has_tag;
  assign has_tag = (used_i < avail_i);

  // Grant when the chain is open and a tag is left (or none is needed).
  // The next free tag is the one at position used_i in the freelist head.
  always_comb begin
    grant_o = en_i & req_i & (~dest_i | has_tag);
    used_o  = used_i + CNT_W'(grant_o & dest_i);
    stall_o = en_i & req_i & dest_i & ~has_tag;
    tag_o   = '0;
    if (grant_o && dest_i) begin
      for (int k = 0; k < DP_NUM; k++) begin
        if (used_i == CNT_W'(k)) tag_o = tags_i[k];
      end
    end
  end
endmodule

module fl_alloc_ctrl #(
  parameter int DP_NUM      = 2,
  parameter int PREG_NUM    = 64,
  parameter int PREG_IDX    = $clog2(PREG_NUM),
  parameter int CNT_W       = $clog2(DP_NUM+1),
  parameter int RB_WAIT_CYC = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DP_NUM-1:0]            dp_req_i,
  input  logic [DP_NUM-1:0]            dp_dest_i,
  input  logic [CNT_W-1:0]             fl_avail_num_i,
  input  logic [DP_NUM*PREG_IDX-1:0]   fl_tag_i,
  input  logic                         rob_rollback_i,
  output logic [DP_NUM-1:0]            dp_grant_o,
  output logic [DP_NUM*PREG_IDX-1:0]   dp_tag_o,
  output logic [CNT_W-1:0]             fl_dp_num_o,
  output logic                         fl_rollback_o,
  output logic                         busy_o,
  output logic                         stall_avail_o
`ifdef FL_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);
  // Wide enough to hold RB_WAIT_CYC-1 even when RB_WAIT_CYC is 1.
  localparam int WAIT_W = $clog2(RB_WAIT_CYC+1);

  typedef enum logic [1:0] {ST_NORMAL, ST_RB, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic                                active;
  logic [CNT_W-1:0]                    avail_eff;
  logic [DP_NUM-1:0][PREG_IDX-1:0]     tags;
  logic [DP_NUM-1:0][PREG_IDX-1:0]     tag_s;
  logic [DP_NUM-1:0]                   grant_s;
  logic [DP_NUM-1:0]                   stall_s;
  logic [DP_NUM:0]                     en_c;
  logic [DP_NUM:0][CNT_W-1:0]          used_c;

  // Grants only flow in NORMAL and never while reset is held.
  assign active    = (state_q == ST_NORMAL) & ~rst_i;
  assign avail_eff = (fl_avail_num_i > CNT_W'(DP_NUM)) ? CNT_W'(DP_NUM) : fl_avail_num_i;
  assign tags      = fl_tag_i;
  assign en_c[0]   = active;
  assign used_c[0] = '0;

  for (genvar i = 0; i < DP_NUM; i++) begin : g_slot
    fl_alloc_slot #(
      .DP_NUM  (DP_NUM),
      .PREG_IDX(PREG_IDX),
      .CNT_W   (CNT_W)
    ) u_slot (
      .en_i   (en_c[i]),
      .req_i  (dp_req_i[i]),
      .dest_i (dp_dest_i[i]),
      .used_i (used_c[i]),
      .avail_i(avail_eff),
      .tags_i (tags),
      .grant_o(grant_s[i]),
      .used_o (used_c[i+1]),
      .tag_o  (tag_s[i]),
      .stall_o(stall_s[i])
    );
    // A denied slot closes the chain for every younger slot.
    assign en_c[i+1] = grant_s[i];
  end

  assign dp_grant_o    = grant_s;
  assign dp_tag_o      = tag_s;
  assign fl_dp_num_o   = used_c[DP_NUM];
  // At most one slot can see an open chain and still be denied: the oldest denial.
  assign stall_avail_o = |stall_s;
  assign fl_rollback_o = (state_q == ST_RB) & ~rst_i;
  assign busy_o        = ((state_q == ST_RB) | (state_q == ST_WAIT)) & ~rst_i;

  // Rollback sequencer next state: any rollback request (re)enters RB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (rob_rollback_i) state_d = ST_RB;
      end
      ST_RB: begin
        if (rob_rollback_i) begin
          state_d = ST_RB;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_W'(RB_WAIT_CYC-1);
        end
      end
      ST_WAIT: begin
        if (rob_rollback_i) begin
          state_d = ST_RB;
        end else if (cnt_q == '0) begin
          state_d = ST_NORMAL;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_NORMAL;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset beats a concurrent rollback request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of tag-starvation cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_avail_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: doc/fl_alloc_ctrl.md
Name: fl_alloc_ctrl

Overview:
Allocation controller between dispatch and the physical-register freelist. Each cycle it decides which dispatch slots may proceed, in program order, given the freelist's available-tag count. It steers freelist tags to the granted slots that write a destination and drives the freelist pop count. It also sequences branch-mispredict rollback: it pulses the freelist rollback, then blocks dispatch for a fixed recovery window.

Parameters:
DP_NUM, 2, dispatch slots per cycle
PREG_NUM, 64, physical registers; PREG_IDX = $clog2(PREG_NUM)
CNT_W, $clog2(DP_NUM+1), width of slot-count fields
RB_WAIT_CYC, 2, recovery cycles after rollback pulse (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
dp_req_i  in  DP_NUM  slot i holds a valid instruction
dp_dest_i  in  DP_NUM  slot i writes a destination (needs a tag)
fl_avail_num_i  in  CNT_W  tags the freelist can supply this cycle (0..DP_NUM)
fl_tag_i  in  DP_NUM*PREG_IDX  freelist head tags; index 0 is the oldest
rob_rollback_i  in  1  mispredict rollback request from ROB
dp_grant_o  out  DP_NUM  slot i may dispatch this cycle
dp_tag_o  out  DP_NUM*PREG_IDX  tag assigned to slot i (0 when slot not granted or no dest)
fl_dp_num_o  out  CNT_W  tags popped from freelist this cycle
fl_rollback_o  out  1  freelist rollback strobe
busy_o  out  1  rollback sequencing in progress
stall_avail_o  out  1  a requesting slot was denied solely for lack of tags

Behaviour:
- Clock/reset: one clock, clk_i; rst_i is synchronous and active-high. Reset value: state NORMAL, wait counter 0. All outputs 0 during and right after reset (grants are combinational from inputs in NORMAL).
- FSM states: NORMAL, RB, WAIT. The state is registered. Grant logic is combinational from the current state and the inputs, with zero latency.
- NORMAL, in-order grant:
  - Slot i is granted iff dp_req_i[i] is set and every slot j<i is granted.
  - It also needs either dp_dest_i[i]==0, or the dest count of granted slots before i is less than fl_avail_num_i.
  - The first denial blocks all younger slots. A gap (req=0 in slot j) blocks younger slots.
- Tag steering: for a granted dest slot i, k = number of granted dest slots before i, and dp_tag_o[i] = fl_tag_i[k].
- fl_dp_num_o = popcount(granted & dp_dest_i). It never exceeds fl_avail_num_i.
- stall_avail_o = 1 iff in NORMAL, the oldest denied slot has req=1, dest=1, and the tag count is exhausted.
- Rollback entry: rob_rollback_i in NORMAL moves the FSM to RB next cycle. Grants that same cycle are still issued; the rollback squashes younger work downstream.
- RB state, one cycle:
  - fl_rollback_o=1, busy_o=1, all grants 0, fl_dp_num_o=0.
  - Next state is WAIT with counter = RB_WAIT_CYC-1.
- WAIT state:
  - busy_o=1, grants 0, fl_rollback_o=0.
  - The counter decrements each cycle. When the counter is 0, next state is NORMAL.
  - Total dispatch blackout after a rollback request = 1+RB_WAIT_CYC cycles.
- rob_rollback_i asserted in RB or WAIT returns the FSM to RB next cycle, which restarts the full sequence.
- rob_rollback_i together with rst_i: reset wins.
- fl_avail_num_i greater than DP_NUM is treated as DP_NUM.
- Wrap-around and full/empty are owned by the freelist. fl_avail_num_i==0 with only dest-less requests still grants all of them.

Optional Feature:
- FL_STALL_CNT_EN: when defined, adds output stall_cnt_o [31:0].
  - Counts cycles with stall_avail_o=1 and saturates at 0xFFFFFFFF.
  - Cleared by rst_i.
  - Does not count RB/WAIT cycles.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with req=2'b11 -> grants 0, fl_dp_num_o=0, fl_rollback_o=0, busy_o=0. After release, NORMAL grants resume in the same cycle.
- Full grant: req=11, dest=11, avail=2, tags {9,8} -> grant=11, dp_tag_o[0]=8, dp_tag_o[1]=9, fl_dp_num_o=2, stall_avail_o=0.
- Partial tags: req=11, dest=11, avail=1 -> grant=01, tag[0]=8, fl_dp_num_o=1, stall_avail_o=1.
- Dest-less slot: req=11, dest=10, avail=1 -> grant=11, tag[0]=0, tag[1]=8, fl_dp_num_o=1.
- Gap: req=10 -> grant=00, fl_dp_num_o=0, stall_avail_o=0.
- Rollback (RB_WAIT_CYC=2): one-cycle rob_rollback_i with req=11, avail=2 -> next cycle fl_rollback_o=1 and grant=00; then 2 WAIT cycles with busy_o=1; 4th cycle after the request grant=11. A second rollback during WAIT restarts the sequence from RB.
